uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_defines.sv | 11 +
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arb.sv | 127 ++++++++++++
 tb/tb_uart_tx_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_defines.sv
// Shared types and limits for the UART transmit arbiter.
package uart_defines;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } uart_arb_state_t;

   localparam int UART_ARB_MAX_REQ = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: the first requester found after
// i_last_grant (wrapping modulo NUM_REQ) wins.
module uart_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IW      = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_last_grant,
   output logic               o_valid,
   output logic [IW-1:0]      o_winner
);

   logic [IW-1:0] w_cand;

   // Scan from the farthest candidate down so the nearest one after
   // i_last_grant is written last and therefore wins.
   always_comb begin
      o_valid  = 1'b0;
      o_winner = '0;
      w_cand   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = IW'((int'(i_last_grant) + k) % NUM_REQ);
         if (i_req[w_cand]) begin
            o_valid  = 1'b1;
            o_winner = w_cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting whole messages from NUM_REQ byte streams to one
// UART TX PHY. Define UART_ARB_TIMEOUT_EN to force-release stalled owners.
module uart_tx_arb
   import uart_defines::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0][7:0] req_data,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_last,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   output logic                    timeout
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > UART_ARB_MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("uart_tx_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
   end

   uart_arb_state_t r_state;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   r_last_grant;

   logic            w_locked;
   logic            w_xfer;
   logic            w_pick_valid;
   logic [IW-1:0]   w_pick;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_valid      (w_pick_valid),
      .o_winner     (w_pick)
   );

   // Gating with rst keeps every output quiet during reset, so a message cut
   // short by reset cannot sneak out one more byte on the reset cycle.
   assign w_locked = (r_state == ARB_LOCKED) && !rst;
   assign w_xfer   = w_locked && req_valid[r_owner] && tx_ready;
   assign busy     = w_locked;

   always_comb begin
      req_ready = '0;
      grant     = '0;
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      if (w_locked) begin
         req_ready[r_owner] = tx_ready;
         grant[r_owner]     = 1'b1;
         tx_data            = req_data[r_owner];
         tx_valid           = req_valid[r_owner];
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt;
   logic          r_timeout;

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_owner      <= '0;
         r_last_grant <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
         r_cnt        <= '0;
`endif
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_valid) begin
                  r_owner <= w_pick;
                  r_state <= ARB_LOCKED;
`ifdef UART_ARB_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            ARB_LOCKED: begin
               if (w_xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                  r_cnt <= '0;
`endif
                  if (req_last[r_owner]) begin
                     r_state      <= ARB_IDLE;
                     r_last_grant <= r_owner;
                  end
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (!req_valid[r_owner]) begin
                  if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                     r_state      <= ARB_IDLE;
                     r_last_grant <= r_owner;
                     r_timeout    <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`endif
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with two requesters; the stall scenario
// expects a forced release only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0][7:0]  req_data;
   logic [1:0]       req_valid;
   logic [1:0]       req_last;
   logic [1:0]       req_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [1:0]       grant;
   logic             busy;
   logic             timeout;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_arb #(
      .NUM_REQ        (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .grant     (grant),
      .busy      (busy),
      .timeout   (timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: sample outputs on the falling edge, then step past the
   // rising edge so the caller can drive the next cycle's inputs.
   task automatic cyc(input string tag, input logic [1:0] eg, input logic ev,
                      input logic [7:0] ed, input logic eb, input logic [1:0] er,
                      input logic et);
      @(negedge clk);
      check({tag, ".grant"},     32'(grant),     32'(eg));
      check({tag, ".tx_valid"},  32'(tx_valid),  32'(ev));
      if (ev) check({tag, ".tx_data"}, 32'(tx_data), 32'(ed));
      check({tag, ".busy"},      32'(busy),      32'(eb));
      check({tag, ".req_ready"}, 32'(req_ready), 32'(er));
      check({tag, ".timeout"},   32'(timeout),   32'(et));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] l,
                        input logic [7:0] d0, input logic [7:0] d1);
      req_valid   = v;
      req_last    = l;
      req_data[0] = d0;
      req_data[1] = d1;
   endtask

   // Reset with both requesters asserting valid; outputs must stay silent.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      tx_ready = 1'b1;
      drive(2'b11, 2'b11, 8'hEE, 8'hDD);
      cyc(tag, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc(tag, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      drive(2'b00, 2'b00, 8'h00, 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      tx_ready = 1'b1;
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      @(posedge clk);
      #1;

      // Three-byte message from req0.
      do_reset("rst0");
      drive(2'b01, 2'b00, 8'h41, 8'h00);
      cyc("m3.idle", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("m3.b0",   2'b01, 1'b1, 8'h41, 1'b1, 2'b01, 1'b0);
      drive(2'b01, 2'b00, 8'h42, 8'h00);
      cyc("m3.b1",   2'b01, 1'b1, 8'h42, 1'b1, 2'b01, 1'b0);
      drive(2'b01, 2'b01, 8'h43, 8'h00);
      cyc("m3.b2",   2'b01, 1'b1, 8'h43, 1'b1, 2'b01, 1'b0);
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("m3.done", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      // Simultaneous requests: req0 wins, finishes, one idle cycle, then req1.
      do_reset("rst1");
      drive(2'b11, 2'b00, 8'hA0, 8'hB0);
      cyc("both.idle0", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("both.a0",    2'b01, 1'b1, 8'hA0, 1'b1, 2'b01, 1'b0);
      drive(2'b11, 2'b01, 8'hA1, 8'hB0);
      cyc("both.a1",    2'b01, 1'b1, 8'hA1, 1'b1, 2'b01, 1'b0);
      drive(2'b10, 2'b00, 8'h00, 8'hB0);
      cyc("both.idle1", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("both.b0",    2'b10, 1'b1, 8'hB0, 1'b1, 2'b10, 1'b0);
      drive(2'b10, 2'b10, 8'h00, 8'hB1);
      cyc("both.b1",    2'b10, 1'b1, 8'hB1, 1'b1, 2'b10, 1'b0);
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("both.done",  2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      // PHY back-pressure for 20 cycles in the middle of a message.
      do_reset("rst2");
      drive(2'b01, 2'b00, 8'h10, 8'h00);
      cyc("bp.idle", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("bp.b0",   2'b01, 1'b1, 8'h10, 1'b1, 2'b01, 1'b0);
      drive(2'b01, 2'b00, 8'h11, 8'h00);
      tx_ready = 1'b0;
      for (int i = 0; i < 20; i++)
         cyc("bp.hold", 2'b01, 1'b1, 8'h11, 1'b1, 2'b00, 1'b0);
      tx_ready = 1'b1;
      cyc("bp.b1",   2'b01, 1'b1, 8'h11, 1'b1, 2'b01, 1'b0);
      drive(2'b01, 2'b01, 8'h12, 8'h00);
      cyc("bp.b2",   2'b01, 1'b1, 8'h12, 1'b1, 2'b01, 1'b0);
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("bp.done", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      // Reset after the first of three bytes abandons the message.
      do_reset("rst3");
      drive(2'b01, 2'b00, 8'h31, 8'h00);
      cyc("mr.idle", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("mr.b0",   2'b01, 1'b1, 8'h31, 1'b1, 2'b01, 1'b0);
      drive(2'b01, 2'b00, 8'h32, 8'h00);
      rst = 1'b1;
      cyc("mr.inrst", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      drive(2'b10, 2'b10, 8'h00, 8'h81);
      cyc("mr.post",  2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("mr.r1",    2'b10, 1'b1, 8'h81, 1'b1, 2'b10, 1'b0);
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("mr.done",  2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      // Owner stalls after byte 1 while req1 waits.
      do_reset("rst4");
      drive(2'b11, 2'b10, 8'h61, 8'h71);
      cyc("st.idle", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("st.b0",   2'b01, 1'b1, 8'h61, 1'b1, 2'b01, 1'b0);
      drive(2'b10, 2'b10, 8'h00, 8'h71);
`ifdef UART_ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++)
         cyc("st.wait", 2'b01, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0);
      cyc("st.tmo",  2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
      cyc("st.r1",   2'b10, 1'b1, 8'h71, 1'b1, 2'b10, 1'b0);
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("st.done", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
`else
      for (int i = 0; i < 40; i++)
         cyc("st.hold", 2'b01, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0);
      drive(2'b11, 2'b11, 8'h62, 8'h71);
      cyc("st.b1",   2'b01, 1'b1, 8'h62, 1'b1, 2'b01, 1'b0);
      drive(2'b10, 2'b10, 8'h00, 8'h71);
      cyc("st.idle1", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      cyc("st.r1",   2'b10, 1'b1, 8'h71, 1'b1, 2'b10, 1'b0);
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("st.done", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
`endif

      // Continuous single-byte messages from both: grants alternate.
      do_reset("rst5");
      drive(2'b11, 2'b11, 8'h55, 8'hAA);
      for (int r = 0; r < 3; r++) begin
         cyc("alt.idle0", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
         cyc("alt.r0",    2'b01, 1'b1, 8'h55, 1'b1, 2'b01, 1'b0);
         cyc("alt.idle1", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
         cyc("alt.r1",    2'b10, 1'b1, 8'hAA, 1'b1, 2'b10, 1'b0);
      end

      // A lone requester is re-granted after every message.
      drive(2'b01, 2'b01, 8'h77, 8'h00);
      for (int r = 0; r < 3; r++) begin
         cyc("solo.idle", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
         cyc("solo.r0",   2'b01, 1'b1, 8'h77, 1'b1, 2'b01, 1'b0);
      end
      drive(2'b00, 2'b00, 8'h00, 8'h00);
      cyc("solo.done", 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
